mem_bank_ctrl: RTL and testbench

Parametrised successor to mem_sys. Provides two independent memory channels, X (activations) and W (weights). Each channel has N_BANKS selectable banks, configurable word width, single-cycle writes, and a burst-read sequencer that streams consecutive words with a valid strobe. It sits between the input loader and the MAC array, replacing the per-address read loop with hardware streaming.

---
 rtl/mem_bank_pkg.sv | 19 +
 rtl/mem_bank_port.sv | 118 +++++++++++
 rtl/mem_bank_ctrl.sv | 83 ++++++++
 tb/tb_mem_bank_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bank_pkg.sv
// Shared definitions for the dual-channel banked memory controller:
// burst sequencer state encoding and bank-select width helper.
package mem_bank_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_READ = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // A single bank still needs a one-bit select port.
  function automatic int sel_w(input int n_banks);
    return (n_banks > 1) ? $clog2(n_banks) : 1;
  endfunction

  localparam int N_BANKS_DEF = 4;
  localparam int SEL_W       = sel_w(N_BANKS_DEF);

endpackage

// File: rtl/mem_bank_port.sv
// One memory channel: banked word array with single-cycle writes and a
// burst-read sequencer that streams consecutive words with a valid strobe.
module mem_bank_port
  import mem_bank_pkg::*;
#(
  parameter  int DATA_W  = 1,
  parameter  int ADDR_W  = 10,
  parameter  int N_BANKS = 4,
  parameter  int LEN_W   = 8,
  localparam int BSEL_W  = sel_w(N_BANKS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [BSEL_W-1:0] i_sel,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_rd_start,
  input  logic [LEN_W-1:0]  i_rd_len,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_wr_err
);

  localparam int MEM_WORDS = 1 << (BSEL_W + ADDR_W);

  logic [DATA_W-1:0] r_mem [MEM_WORDS];

  state_t              r_state;
  logic [BSEL_W-1:0]   r_sel;
  logic [ADDR_W-1:0]   r_ptr;
  logic [LEN_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_data;
  logic                r_valid;
  logic                r_done;
  logic                r_wr_err;

  logic                       w_idle;
  logic                       w_wr_en;
  logic [BSEL_W+ADDR_W-1:0]   w_wr_idx;
  logic [BSEL_W+ADDR_W-1:0]   w_rd_idx;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_wr_en  = i_we && w_idle;
  assign w_wr_idx = {i_sel, i_addr};
  // The pointer wraps inside its ADDR_W field, so a burst never leaves the latched bank.
  assign w_rd_idx = {r_sel, r_ptr};

  // NOTE: the word array has no reset; contents survive rst_n and the
  // array maps onto plain RAM without a per-word clear path.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_idx] <= i_data;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_sel    <= '0;
      r_ptr    <= '0;
      r_cnt    <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_done   <= 1'b0;
      r_wr_err <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_done  <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (i_rd_start) begin
            r_sel   <= i_sel;
            r_ptr   <= i_addr;
            r_cnt   <= i_rd_len;
            r_state <= (i_rd_len == '0) ? ST_DONE : ST_READ;
          end
        end

        ST_READ: begin
          r_data  <= r_mem[w_rd_idx];
          r_valid <= 1'b1;
          r_ptr   <= r_ptr + ADDR_W'(1);
          r_cnt   <= r_cnt - LEN_W'(1);
          if (r_cnt == LEN_W'(1)) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end

        ST_DONE: begin
          // A non-empty burst already pulsed done alongside its last word;
          // a zero-length burst pulses it on the way back to idle.
          r_done  <= ~r_done;
          r_state <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase

      if (i_we && !w_idle) begin
        r_wr_err <= 1'b1;
      end
    end
  end

  assign o_data   = r_data;
  assign o_valid  = r_valid;
  assign o_busy   = !w_idle;
  assign o_done   = r_done;
  assign o_wr_err = r_wr_err;

endmodule

// File: rtl/mem_bank_ctrl.sv
// Dual-channel banked memory controller: independent X (activation) and
// W (weight) channels, each a mem_bank_port with its own address width.
module mem_bank_ctrl
  import mem_bank_pkg::*;
#(
  parameter  int DATA_W   = 1,
  parameter  int X_ADDR_W = 10,
  parameter  int W_ADDR_W = 12,
  parameter  int N_BANKS  = 4,
  parameter  int LEN_W    = 8,
  localparam int BSEL_W   = sel_w(N_BANKS)
) (
  input  logic                clk,
  input  logic                rst_n,

  input  logic                x_we,
  input  logic [BSEL_W-1:0]   x_sel,
  input  logic [X_ADDR_W-1:0] x_addr,
  input  logic [DATA_W-1:0]   x_data_in,
  input  logic                x_rd_start,
  input  logic [LEN_W-1:0]    x_rd_len,
  output logic [DATA_W-1:0]   x_data_out,
  output logic                x_valid,
  output logic                x_busy,
  output logic                x_done,
  output logic                x_wr_err,

  input  logic                w_we,
  input  logic [BSEL_W-1:0]   w_sel,
  input  logic [W_ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0]   w_data_in,
  input  logic                w_rd_start,
  input  logic [LEN_W-1:0]    w_rd_len,
  output logic [DATA_W-1:0]   w_data_out,
  output logic                w_valid,
  output logic                w_busy,
  output logic                w_done,
  output logic                w_wr_err
);

  mem_bank_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (X_ADDR_W),
    .N_BANKS (N_BANKS),
    .LEN_W   (LEN_W)
  ) u_x_port (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_we       (x_we),
    .i_sel      (x_sel),
    .i_addr     (x_addr),
    .i_data     (x_data_in),
    .i_rd_start (x_rd_start),
    .i_rd_len   (x_rd_len),
    .o_data     (x_data_out),
    .o_valid    (x_valid),
    .o_busy     (x_busy),
    .o_done     (x_done),
    .o_wr_err   (x_wr_err)
  );

  mem_bank_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (W_ADDR_W),
    .N_BANKS (N_BANKS),
    .LEN_W   (LEN_W)
  ) u_w_port (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_we       (w_we),
    .i_sel      (w_sel),
    .i_addr     (w_addr),
    .i_data     (w_data_in),
    .i_rd_start (w_rd_start),
    .i_rd_len   (w_rd_len),
    .o_data     (w_data_out),
    .o_valid    (w_valid),
    .o_busy     (w_busy),
    .o_done     (w_done),
    .o_wr_err   (w_wr_err)
  );

endmodule

// File: tb/tb_mem_bank_ctrl.sv
// Bench for mem_bank_ctrl (8-bit build): array model of both channels and
// burst timing derived per cycle from burst length and cycle offset.
module tb_mem_bank_ctrl;

  localparam int DATA_W = 8;
  localparam int XA     = 10;
  localparam int WA     = 12;
  localparam int NB     = 4;
  localparam int LW     = 8;
  localparam int XD     = 1 << XA;
  localparam int WD     = 1 << WA;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          x_we, x_rd_start, w_we, w_rd_start;
  logic [1:0]    x_sel, w_sel;
  logic [XA-1:0] x_addr;
  logic [WA-1:0] w_addr;
  logic [7:0]    x_data_in, w_data_in;
  logic [LW-1:0] x_rd_len, w_rd_len;
  logic [7:0]    x_data_out, w_data_out;
  logic          x_valid, x_busy, x_done, x_wr_err;
  logic          w_valid, w_busy, w_done, w_wr_err;

  always #5 clk = ~clk;

  mem_bank_ctrl #(
    .DATA_W(DATA_W), .X_ADDR_W(XA), .W_ADDR_W(WA), .N_BANKS(NB), .LEN_W(LW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .x_we(x_we), .x_sel(x_sel), .x_addr(x_addr), .x_data_in(x_data_in),
    .x_rd_start(x_rd_start), .x_rd_len(x_rd_len), .x_data_out(x_data_out),
    .x_valid(x_valid), .x_busy(x_busy), .x_done(x_done), .x_wr_err(x_wr_err),
    .w_we(w_we), .w_sel(w_sel), .w_addr(w_addr), .w_data_in(w_data_in),
    .w_rd_start(w_rd_start), .w_rd_len(w_rd_len), .w_data_out(w_data_out),
    .w_valid(w_valid), .w_busy(w_busy), .w_done(w_done), .w_wr_err(w_wr_err)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: memory contents, last presented word, sticky error.
  logic [7:0] mx [NB][XD];
  logic [7:0] mw [NB][WD];
  logic [7:0] exp_xq = 8'h00;
  logic [7:0] exp_wq = 8'h00;
  logic       exp_xerr = 1'b0;
  logic       exp_werr = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    x_we = 0; x_rd_start = 0; x_sel = 0; x_addr = 0; x_data_in = 0; x_rd_len = 0;
    w_we = 0; w_rd_start = 0; w_sel = 0; w_addr = 0; w_data_in = 0; w_rd_len = 0;
  endtask

  task automatic x_write(input int sel, input int addr, input logic [7:0] data);
    x_we = 1; x_sel = 2'(sel); x_addr = XA'(addr); x_data_in = data;
    step();
    x_we = 0;
    mx[sel][addr] = data;
  endtask

  task automatic w_write(input int sel, input int addr, input logic [7:0] data);
    w_we = 1; w_sel = 2'(sel); w_addr = WA'(addr); w_data_in = data;
    step();
    w_we = 0;
    mw[sel][addr] = data;
  endtask

  task automatic preload();
    for (int b = 0; b < NB; b++) begin
      for (int a = 0; a < WD; a++) begin
        w_we = 1; w_sel = 2'(b); w_addr = WA'(a); w_data_in = 8'($urandom);
        mw[b][a] = w_data_in;
        x_we = (a < XD);
        if (a < XD) begin
          x_sel = 2'(b); x_addr = XA'(a); x_data_in = 8'($urandom);
          mx[b][a] = x_data_in;
        end
        step();
      end
    end
    x_we = 0; w_we = 0;
  endtask

  // Launches optional bursts on X and W in the same cycle, then compares
  // every cycle. Cycle k counts from the edge that samples rd_start.
  // xwe_at / xstart_at inject an X write or a second start in cycle k.
  task automatic run_bursts(input string name,
                            input bit dx, input int xsel, input int xbase, input int xlen,
                            input bit dw, input int wsel, input int wbase, input int wlen,
                            input int xwe_at, input int xwe_addr, input int xstart_at);
    int lx, lw, ncyc;
    lx = dx ? ((xlen == 0) ? 1 : xlen) : 0;
    lw = dw ? ((wlen == 0) ? 1 : wlen) : 0;
    ncyc = ((lx > lw) ? lx : lw) + 2;
    x_sel = 2'(xsel); x_addr = XA'(xbase); x_rd_len = LW'(xlen); x_rd_start = dx;
    w_sel = 2'(wsel); w_addr = WA'(wbase); w_rd_len = LW'(wlen); w_rd_start = dw;
    step();
    x_rd_start = 0; w_rd_start = 0; x_we = 0; w_we = 0;
    for (int k = 0; k < ncyc; k++) begin
      logic xv, xb, xd, wv, wb, wd;
      xb = dx && ((xlen == 0) ? (k == 0) : (k <= xlen));
      xv = dx && (xlen != 0) && (k >= 1) && (k <= xlen);
      xd = dx && ((xlen == 0) ? (k == 1) : (k == xlen));
      wb = dw && ((wlen == 0) ? (k == 0) : (k <= wlen));
      wv = dw && (wlen != 0) && (k >= 1) && (k <= wlen);
      wd = dw && ((wlen == 0) ? (k == 1) : (k == wlen));
      if (xv) exp_xq = mx[xsel][(xbase + k - 1) % XD];
      if (wv) exp_wq = mw[wsel][(wbase + k - 1) % WD];

      vectors++;
      if ({x_valid, x_busy, x_done, x_wr_err, x_data_out} !== {xv, xb, xd, exp_xerr, exp_xq}) begin
        miscompares++;
        $display("FAIL %s X cycle %0d: got v/b/d/err=%b%b%b%b data=%h, expected %b%b%b%b data=%h",
                 name, k, x_valid, x_busy, x_done, x_wr_err, x_data_out, xv, xb, xd, exp_xerr, exp_xq);
      end
      vectors++;
      if ({w_valid, w_busy, w_done, w_wr_err, w_data_out} !== {wv, wb, wd, exp_werr, exp_wq}) begin
        miscompares++;
        $display("FAIL %s W cycle %0d: got v/b/d/err=%b%b%b%b data=%h, expected %b%b%b%b data=%h",
                 name, k, w_valid, w_busy, w_done, w_wr_err, w_data_out, wv, wb, wd, exp_werr, exp_wq);
      end

      if (k == xwe_at) begin
        x_we = 1; x_sel = 2'(xsel); x_addr = XA'(xwe_addr); x_data_in = ~mx[xsel][xwe_addr];
        if (xb) exp_xerr = 1'b1;
        else    mx[xsel][xwe_addr] = x_data_in;
      end
      if (k == xstart_at && xb) begin
        x_rd_start = 1; x_sel = 2'((xsel + 1) % NB); x_addr = '0; x_rd_len = 8'd7;
      end
      step();
      x_we = 0; x_rd_start = 0;
    end
  endtask

  task automatic test_reset();
    drive_idle();
    #2 rst_n = 1'b0;
    #2;
    vectors++;
    if ({x_valid, x_busy, x_done, x_wr_err, x_data_out, w_valid, w_busy, w_done, w_wr_err, w_data_out} !== '0) begin
      miscompares++;
      $display("FAIL reset: got X v/b/d/err=%b%b%b%b data=%h W v/b/d/err=%b%b%b%b data=%h, expected all 0",
               x_valid, x_busy, x_done, x_wr_err, x_data_out, w_valid, w_busy, w_done, w_wr_err, w_data_out);
    end
    @(negedge clk) rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    x_write(2, 0, 8'd1); x_write(2, 1, 8'd0); x_write(2, 2, 8'd1);
    run_bursts("basic", 1, 2, 0, 3, 0, 0, 0, 0, -1, 0, -1);
  endtask

  task automatic test_wrap();
    x_write(1, XD - 1, 8'd1); x_write(1, 0, 8'd0); x_write(0, 0, 8'd1);
    run_bursts("wrap_x", 1, 1, XD - 1, 2, 0, 0, 0, 0, -1, 0, -1);
    run_bursts("wrap_w", 0, 0, 0, 0, 1, 3, WD - 2, 4, -1, 0, -1);
  endtask

  task automatic test_len_zero();
    run_bursts("len0_x", 1, 0, 7, 0, 0, 0, 0, 0, -1, 0, -1);
    run_bursts("len0_w", 0, 0, 0, 0, 1, 2, 9, 0, -1, 0, -1);
  endtask

  task automatic test_write_busy();
    run_bursts("wr_busy", 1, 2, 3, 4, 0, 0, 0, 0, 1, 5, -1);
    run_bursts("wr_busy_rb", 1, 2, 5, 1, 0, 0, 0, 0, -1, 0, -1);
  endtask

  task automatic test_start_ignored();
    run_bursts("start_busy", 1, 3, 40, 5, 0, 0, 0, 0, -1, 0, 2);
  endtask

  task automatic test_same_edge();
    x_we = 1; x_data_in = ~mx[3][100];
    mx[3][100] = x_data_in;
    run_bursts("same_edge", 1, 3, 100, 2, 0, 0, 0, 0, -1, 0, -1);
  endtask

  task automatic test_concurrent();
    logic [7:0] pat [5];
    pat[0] = 8'hA5; pat[1] = 8'h3C; pat[2] = 8'h5A; pat[3] = 8'hC3; pat[4] = 8'h0F;
    for (int i = 0; i < 5; i++) w_write(0, 10 + i, pat[i]);
    run_bursts("concurrent", 1, 1, 20, 3, 1, 0, 10, 5, -1, 0, -1);
  endtask

  task automatic test_reset_mid_burst();
    w_sel = 2'd3; w_addr = WA'(4000); w_rd_len = 8'd8; w_rd_start = 1;
    step();
    w_rd_start = 0;
    repeat (3) step();
    vectors++;
    if ({w_valid, w_busy, w_data_out} !== {1'b1, 1'b1, mw[3][4002]}) begin
      miscompares++;
      $display("FAIL rst_mid pre: got v/b=%b%b data=%h, expected 11 data=%h",
               w_valid, w_busy, w_data_out, mw[3][4002]);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({w_valid, w_busy, w_done, w_wr_err, x_wr_err, w_data_out} !== '0) begin
      miscompares++;
      $display("FAIL rst_mid async: got W v/b/d/err=%b%b%b%b X err=%b data=%h, expected all 0",
               w_valid, w_busy, w_done, w_wr_err, x_wr_err, w_data_out);
    end
    exp_xq = 0; exp_wq = 0; exp_xerr = 0; exp_werr = 0;
    @(negedge clk) rst_n = 1'b1;
    step();
    run_bursts("rst_mid_after", 0, 0, 0, 0, 1, 3, 4000, 8, -1, 0, -1);
  endtask

  task automatic test_random();
    for (int it = 0; it < 25; it++) begin
      int nwr;
      nwr = $urandom_range(0, 3);
      for (int j = 0; j < nwr; j++) begin
        x_write($urandom_range(0, NB - 1), $urandom_range(0, XD - 1), 8'($urandom));
        w_write($urandom_range(0, NB - 1), $urandom_range(0, WD - 1), 8'($urandom));
      end
      run_bursts("random",
                 1'($urandom), $urandom_range(0, NB - 1),
                 (it % 4 == 0) ? XD - 3 : $urandom_range(0, XD - 1), $urandom_range(0, 12),
                 1'($urandom), $urandom_range(0, NB - 1),
                 (it % 5 == 0) ? WD - 2 : $urandom_range(0, WD - 1), $urandom_range(0, 12),
                 -1, 0, -1);
    end
  endtask

  initial begin
    test_reset();
    preload();
    test_basic();
    test_wrap();
    test_len_zero();
    test_write_busy();
    test_start_ignored();
    test_same_edge();
    test_concurrent();
    test_reset_mid_burst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
